// File: rtl/cache_control.sv
// cache_control: direct-mapped, write-back, write-allocate L1 cache controller.
// It owns the tag, valid, dirty and 256-bit line arrays. It checks for hits,
// writes back a dirty victim line and fills a line from physical memory.
//
// Optional feature: define CACHE_PERF_CNT_EN to enable the saturating
// hit/miss performance counters. Without it both counters read 32'h0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   mem_read, mem_write   CPU request, held until mem_resp
//   mem_byte_enable       byte lanes of the aligned store word
//   mem_address           CPU byte address {tag, index, offset[4:0]}
//   mem_wdata             lane-aligned store data
//   mem_rdata, mem_resp   load data and one-cycle completion pulse
//   pmem_read/pmem_write  line fill / writeback request, held until pmem_resp
//   pmem_address          line address (bits [4:0] = 0)
//   pmem_wdata/pmem_rdata victim line out / fill line in
//   pmem_resp             pmem completion pulse
//   hit_count, miss_count performance counters
module cache_control #(
  parameter int IDX_W = 3,
  parameter int TAG_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int SETS = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

  state_t state;

  // Latched request
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [2:0]       req_word;
  logic [31:0]      req_wdata;
  logic [3:0]       req_be;
  logic             req_write;

  // Cache arrays
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [255:0]     line_arr [SETS];
  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;

  logic             hit;
  logic [255:0]     merged_line;

  // Byte offset bits [1:0] are ignored: accesses are word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  assign hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);

  // Current line with the store word merged in under the byte enables.
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    merged_line = line_arr[req_idx];
    for (int i = 0; i < 4; i++) begin
      if (req_be[i])
        merged_line[{req_word, 2'(i), 3'b000} +: 8] = req_wdata[8*i +: 8];
    end
  end

  // Controller FSM with registered outputs; also owns valid/dirty.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      req_tag      <= '0;
      req_idx      <= '0;
      req_word     <= '0;
      req_wdata    <= '0;
      req_be       <= '0;
      req_write    <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            req_tag   <= mem_address[31 -: TAG_W];
            req_idx   <= mem_address[IDX_W+4:5];
            req_word  <= mem_address[4:2];
            req_wdata <= mem_wdata;
            req_be    <= mem_byte_enable;
            req_write <= mem_write;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            mem_resp <= 1'b1;
            if (req_write) dirty[req_idx] <= 1'b1;
            else mem_rdata <= line_arr[req_idx][{req_word, 5'b00000} +: 32];
            state <= IDLE;
          end else if (valid[req_idx] && dirty[req_idx]) begin
            pmem_write   <= 1'b1;
            pmem_address <= {tag_arr[req_idx], req_idx, 5'b00000};
            pmem_wdata   <= line_arr[req_idx];
            state        <= WRITEBACK;
          end else begin
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, req_idx, 5'b00000};
            state        <= FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, req_idx, 5'b00000};
            state        <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            pmem_read      <= 1'b0;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            state          <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and line storage. Writes are qualified by FSM state, which reset
  // forces to IDLE, so an abandoned miss never touches the arrays.
  // NOTE: storage arrays are deliberately not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == FILL && pmem_resp) begin
      line_arr[req_idx] <= pmem_rdata;
      tag_arr[req_idx]  <= req_tag;
    end else if (state == CHECK && hit && req_write) begin
      line_arr[req_idx] <= merged_line;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // refill marks the CHECK that follows a fill; its hit is not counted.
  logic refill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      refill     <= 1'b0;
    end else begin
      if (state == FILL && pmem_resp) refill <= 1'b1;
      else if (state == CHECK)        refill <= 1'b0;
      if (state == CHECK) begin
        if (!hit) begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end else if (!refill) begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end
      end
    end
  end
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule
